// File: rtl/nrisc_banked_regfile_pkg.sv
// Shared widths and FSM encoding for the NRISC banked register file.
// Imported by the interface, the storage array and the top level.
package nrisc_regs_pkg;

  function automatic int rw_f(input int nregs);
    return $clog2(nregs);
  endfunction

  // One bank still needs a one-bit select so the port never collapses to zero width.
  function automatic int bw_f(input int nbanks);
    return (nbanks > 1) ? $clog2(nbanks) : 1;
  endfunction

  localparam logic [1:0] S_CLR_ALL  = 2'd0;
  localparam logic [1:0] S_IDLE     = 2'd1;
  localparam logic [1:0] S_CLR_BANK = 2'd2;

  typedef enum logic [1:0] {
    ST_CLR_ALL  = S_CLR_ALL,
    ST_IDLE     = S_IDLE,
    ST_CLR_BANK = S_CLR_BANK
  } state_e;

endpackage

// File: rtl/nrisc_banked_regfile_if.sv
// Decode-side bus of the register file: read/write indices, data, bank control and status.
// master = decode/control side, slave = register file.
interface nrisc_banked_regfile_if
  import nrisc_regs_pkg::*;
#(
  parameter int TAM = 16,
  parameter int RW  = rw_f(16),
  parameter int BW  = bw_f(2)
);
  logic [RW-1:0]  REG_RF1;
  logic [RW-1:0]  REG_RF2;
  logic [RW-1:0]  REG_RFD;
  logic [TAM-1:0] REG_D;
  logic           REG_Write;
  logic [TAM-1:0] REG_R1;
  logic [BW-1:0]  REG_Bank_sel;
  logic           REG_Bank_load;
  logic           REG_Clear;
  logic [TAM-1:0] REG_A;
  logic [TAM-1:0] REG_B;
  logic [BW-1:0]  REG_Bank;
  logic           REG_Ready;

  modport master (
    output REG_RF1, REG_RF2, REG_RFD, REG_D, REG_Write, REG_R1,
           REG_Bank_sel, REG_Bank_load, REG_Clear,
    input  REG_A, REG_B, REG_Bank, REG_Ready
  );

  modport slave (
    input  REG_RF1, REG_RF2, REG_RFD, REG_D, REG_Write, REG_R1,
           REG_Bank_sel, REG_Bank_load, REG_Clear,
    output REG_A, REG_B, REG_Bank, REG_Ready
  );
endinterface

// File: rtl/nrisc_banked_regfile_reg_bank.sv
// One storage array: synchronous write with a row-clear port, two asynchronous read ports.
// Contents have no reset; the owning sequencer zeroes them row by row.
module nrisc_reg_bank #(
  parameter  int DEPTH = 16,
  parameter  int TAM   = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [TAM-1:0] wdata,
  input  logic           clr,
  input  logic [AW-1:0]  caddr,
  input  logic [AW-1:0]  raddr_a,
  input  logic [AW-1:0]  raddr_b,
  output logic [TAM-1:0] rdata_a,
  output logic [TAM-1:0] rdata_b
);
  logic [TAM-1:0] mem_q [DEPTH];

  // Clear wins; the controller never asks for both on the same array anyway.
  always_ff @(posedge clk) begin
    if (clr) begin
      mem_q[caddr] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];
endmodule

// File: rtl/nrisc_banked_regfile.sv
// NRISC register file: R0=0, R1=external, globals, per-level banked sets,
// runtime bank select, hardware zeroing sequencer and write->read bypass.
module nrisc_banked_regfile
  import nrisc_regs_pkg::*;
#(
  parameter int TAM     = 16,
  parameter int NREGS   = 16,
  parameter int NGLOBAL = 8,
  parameter int NBANKS  = 2,
  parameter int BYPASS  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  nrisc_banked_regfile_if.slave  bus
);
  localparam int RW = rw_f(NREGS);
  localparam int BW = bw_f(NBANKS);
  localparam logic [RW-1:0] IDX_FIRST_BANKED = RW'(NGLOBAL);
  localparam logic [RW-1:0] IDX_LAST         = RW'(NREGS - 1);

  state_e         state_q, state_d;
  logic [RW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  bank_q, bank_d;
  logic           clr_all, clr_bank, ready;
  logic           glob_wr_ok, bank_wr_ok, glob_rd_zero, bank_rd_zero;
  logic           wr_is_glob, wr_is_bank, glob_we, wr_accept;
  logic [NBANKS-1:0] bank_we, bank_clr;
  logic [TAM-1:0] glob_rd [2];
  logic [TAM-1:0] bank_rd [NBANKS][2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLR_ALL;
      cnt_q   <= '0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bank_d       = bank_q;
    clr_all      = 1'b0;
    clr_bank     = 1'b0;
    ready        = 1'b0;
    glob_wr_ok   = 1'b0;
    bank_wr_ok   = 1'b0;
    glob_rd_zero = 1'b0;
    bank_rd_zero = 1'b0;
    unique case (state_q)
      ST_CLR_ALL: begin
        clr_all      = 1'b1;
        glob_rd_zero = 1'b1;
        bank_rd_zero = 1'b1;
        cnt_d        = cnt_q + RW'(1);
        if (cnt_q == IDX_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        ready      = 1'b1;
        glob_wr_ok = 1'b1;
        bank_wr_ok = 1'b1;
        if (bus.REG_Bank_load) bank_d = bus.REG_Bank_sel;
        // The clear follows bank_q, so a simultaneous load makes it target the new bank.
        if (bus.REG_Clear) begin
          state_d = ST_CLR_BANK;
          cnt_d   = IDX_FIRST_BANKED;
        end
      end
      ST_CLR_BANK: begin
        clr_bank     = 1'b1;
        bank_rd_zero = 1'b1;
        glob_wr_ok   = 1'b1;
        cnt_d        = cnt_q + RW'(1);
        if (cnt_q == IDX_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLR_ALL;
        cnt_d   = '0;
      end
    endcase
  end

  assign wr_is_bank = (bus.REG_RFD >= IDX_FIRST_BANKED);
  assign wr_is_glob = (bus.REG_RFD >= RW'(2)) && !wr_is_bank;
  assign glob_we    = bus.REG_Write && glob_wr_ok && wr_is_glob;
  assign wr_accept  = glob_we || (|bank_we);

  nrisc_reg_bank #(.DEPTH(NREGS), .TAM(TAM)) u_glob (
    .clk     (clk),
    .we      (glob_we),
    .waddr   (bus.REG_RFD),
    .wdata   (bus.REG_D),
    .clr     (clr_all),
    .caddr   (cnt_q),
    .raddr_a (bus.REG_RF1),
    .raddr_b (bus.REG_RF2),
    .rdata_a (glob_rd[0]),
    .rdata_b (glob_rd[1])
  );

  for (genvar gi = 0; gi < NBANKS; gi++) begin : g_bank
    // Writes land in the bank active before any same-cycle load.
    assign bank_we[gi]  = bus.REG_Write && bank_wr_ok && wr_is_bank && (bank_q == BW'(gi));
    assign bank_clr[gi] = clr_all || (clr_bank && (bank_q == BW'(gi)));

    nrisc_reg_bank #(.DEPTH(NREGS), .TAM(TAM)) u_bank (
      .clk     (clk),
      .we      (bank_we[gi]),
      .waddr   (bus.REG_RFD),
      .wdata   (bus.REG_D),
      .clr     (bank_clr[gi]),
      .caddr   (cnt_q),
      .raddr_a (bus.REG_RF1),
      .raddr_b (bus.REG_RF2),
      .rdata_a (bank_rd[gi][0]),
      .rdata_b (bank_rd[gi][1])
    );
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [RW-1:0]  idx;
    logic [TAM-1:0] val;
    assign idx = (gi == 0) ? bus.REG_RF1 : bus.REG_RF2;

    always_comb begin
      if (idx == '0) begin
        val = '0;
      end else if (idx == RW'(1)) begin
        val = bus.REG_R1;
      end else if ((BYPASS != 0) && wr_accept && (bus.REG_RFD == idx)) begin
        val = bus.REG_D;
      end else if (idx < IDX_FIRST_BANKED) begin
        val = glob_rd_zero ? '0 : glob_rd[gi];
      end else begin
        val = bank_rd_zero ? '0 : bank_rd[bank_q][gi];
      end
    end
  end

  assign bus.REG_A     = g_rd[0].val;
  assign bus.REG_B     = g_rd[1].val;
  assign bus.REG_Bank  = bank_q;
  assign bus.REG_Ready = ready;
endmodule

// File: tb/tb_nrisc_banked_regfile.sv
// Bench for nrisc_banked_regfile: a bypassing and a non-bypassing instance share one
// stimulus stream and are checked against a behavioural register model.
module tb_nrisc_banked_regfile;
  import nrisc_regs_pkg::*;

  localparam int TAM = 16, NREGS = 16, NGLOBAL = 8, NBANKS = 2;
  localparam int RW = rw_f(NREGS), BW = bw_f(NBANKS);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [RW-1:0]  rf1 = '0, rf2 = '0, rfd = '0;
  logic [TAM-1:0] d = '0, r1 = '0;
  logic           wr = 1'b0, load = 1'b0, clr = 1'b0;
  logic [BW-1:0]  sel = '0;

  nrisc_banked_regfile_if #(.TAM(TAM), .RW(RW), .BW(BW)) bus_byp ();
  nrisc_banked_regfile_if #(.TAM(TAM), .RW(RW), .BW(BW)) bus_nb ();

  assign bus_byp.REG_RF1 = rf1;   assign bus_nb.REG_RF1 = rf1;
  assign bus_byp.REG_RF2 = rf2;   assign bus_nb.REG_RF2 = rf2;
  assign bus_byp.REG_RFD = rfd;   assign bus_nb.REG_RFD = rfd;
  assign bus_byp.REG_D = d;       assign bus_nb.REG_D = d;
  assign bus_byp.REG_Write = wr;  assign bus_nb.REG_Write = wr;
  assign bus_byp.REG_R1 = r1;     assign bus_nb.REG_R1 = r1;
  assign bus_byp.REG_Bank_sel = sel;   assign bus_nb.REG_Bank_sel = sel;
  assign bus_byp.REG_Bank_load = load; assign bus_nb.REG_Bank_load = load;
  assign bus_byp.REG_Clear = clr;      assign bus_nb.REG_Clear = clr;

  nrisc_banked_regfile #(.TAM(TAM), .NREGS(NREGS), .NGLOBAL(NGLOBAL), .NBANKS(NBANKS), .BYPASS(1))
    dut_byp (.clk(clk), .rst(rst), .bus(bus_byp.slave));
  nrisc_banked_regfile #(.TAM(TAM), .NREGS(NREGS), .NGLOBAL(NGLOBAL), .NBANKS(NBANKS), .BYPASS(0))
    dut_nb (.clk(clk), .rst(rst), .bus(bus_nb.slave));

  int vecs = 0;
  int errs = 0;

  // Model: register contents plus "cycles still busy" counters; a clear zeroes at once
  // because all affected reads are forced to zero until it completes.
  logic [TAM-1:0] m_glob [NREGS];
  logic [TAM-1:0] m_bank [NBANKS][NREGS];
  int busy_all, busy_bank, m_sel;

  task automatic model_reset();
    busy_all = NREGS; busy_bank = 0; m_sel = 0;
    for (int i = 0; i < NREGS; i++) begin
      m_glob[i] = '0;
      for (int b = 0; b < NBANKS; b++) m_bank[b][i] = '0;
    end
  endtask

  function automatic bit m_wacc();
    return (busy_all == 0) && wr && (int'(rfd) >= 2) && ((int'(rfd) < NGLOBAL) || (busy_bank == 0));
  endfunction

  function automatic logic [TAM-1:0] m_read(input logic [RW-1:0] idx, input bit byp);
    if (idx == 0) return '0;
    if (idx == 1) return r1;
    if (busy_all > 0) return '0;
    if (byp && m_wacc() && rfd == idx) return d;
    if (int'(idx) < NGLOBAL) return m_glob[idx];
    if (busy_bank > 0) return '0;
    return m_bank[m_sel][idx];
  endfunction

  task automatic model_step();
    if (!rst) return;
    if (busy_all > 0) begin
      busy_all--;
      return;
    end
    if (m_wacc()) begin
      if (int'(rfd) < NGLOBAL) m_glob[rfd] = d;
      else m_bank[m_sel][rfd] = d;
    end
    if (busy_bank > 0) begin
      busy_bank--;
    end else begin
      if (load) m_sel = int'(sel);
      if (clr) begin
        for (int i = 0; i < NREGS; i++) m_bank[m_sel][i] = '0;
        busy_bank = NREGS - NGLOBAL;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    int n;
    model_reset();
    r1 = 16'hBEEF; rf1 = 4'd1; rf2 = 4'd9; wr = 1'b1; rfd = 4'd5; d = 16'h5555;
    repeat (3) tick();
    vecs++; if (bus_byp.REG_Ready !== 1'b0 || bus_byp.REG_Bank !== 1'b0) begin errs++;
      $display("FAIL reset_state ready=%b bank=%0d, required ready=0 bank=0", bus_byp.REG_Ready, bus_byp.REG_Bank); end
    rst = 1'b1;
    n = 0;
    while (!bus_byp.REG_Ready && n < 40) begin
      vecs++; if (bus_byp.REG_A !== 16'hBEEF || bus_nb.REG_A !== 16'hBEEF) begin errs++;
        $display("FAIL clr_all_r1 cyc=%0d A=%h/%h, required BEEF", n, bus_byp.REG_A, bus_nb.REG_A); end
      vecs++; if (bus_byp.REG_B !== 16'h0 || bus_nb.REG_B !== 16'h0) begin errs++;
        $display("FAIL clr_all_zero cyc=%0d B=%h/%h, required 0000", n, bus_byp.REG_B, bus_nb.REG_B); end
      tick();
      n++;
    end
    vecs++; if (n != NREGS || bus_nb.REG_Ready !== 1'b1) begin errs++;
      $display("FAIL clr_all_len got %0d cycles, required %0d", n, NREGS); end
    wr = 1'b0; rf1 = 4'd5; #1;
    vecs++; if (bus_byp.REG_A !== 16'h0) begin errs++;
      $display("FAIL clr_all_write_drop R5=%h, required 0000", bus_byp.REG_A); end
    $display("test_reset: ready after %0d cycles", n);
  endtask

  task automatic test_bank_switch();
    rfd = 4'd9; d = 16'h1234; wr = 1'b1; tick();
    wr = 1'b0; load = 1'b1; sel = 1'b1; tick();
    load = 1'b0; rf1 = 4'd9; #1;
    vecs++; if (bus_byp.REG_Bank !== 1'b1 || bus_byp.REG_A !== 16'h0 || bus_nb.REG_A !== 16'h0) begin errs++;
      $display("FAIL bank1_r9 bank=%0d A=%h, required bank=1 A=0000", bus_byp.REG_Bank, bus_byp.REG_A); end
    load = 1'b1; sel = 1'b0; tick();
    load = 1'b0; #1;
    vecs++; if (bus_byp.REG_Bank !== 1'b0 || bus_byp.REG_A !== 16'h1234 || bus_nb.REG_A !== 16'h1234) begin errs++;
      $display("FAIL bank0_r9 bank=%0d A=%h, required bank=0 A=1234", bus_byp.REG_Bank, bus_byp.REG_A); end
    $display("test_bank_switch: R9 bank0=%h", bus_byp.REG_A);
  endtask

  task automatic test_bypass();
    rfd = 4'd3; d = 16'h1111; wr = 1'b1; tick();
    d = 16'hA5A5; rf1 = 4'd3; #1;
    vecs++; if (bus_byp.REG_A !== 16'hA5A5) begin errs++;
      $display("FAIL bypass_on A=%h, required A5A5", bus_byp.REG_A); end
    vecs++; if (bus_nb.REG_A !== 16'h1111) begin errs++;
      $display("FAIL bypass_off_same A=%h, required 1111", bus_nb.REG_A); end
    tick();
    wr = 1'b0; #1;
    vecs++; if (bus_nb.REG_A !== 16'hA5A5 || bus_byp.REG_A !== 16'hA5A5) begin errs++;
      $display("FAIL bypass_off_next A=%h/%h, required A5A5", bus_byp.REG_A, bus_nb.REG_A); end
    wr = 1'b1; rfd = 4'd1; d = 16'h9999; rf1 = 4'd1; rf2 = 4'd0; #1;
    vecs++; if (bus_byp.REG_A !== 16'hBEEF || bus_byp.REG_B !== 16'h0) begin errs++;
      $display("FAIL bypass_low_idx A=%h B=%h, required BEEF 0000", bus_byp.REG_A, bus_byp.REG_B); end
    tick();
    wr = 1'b0;
    $display("test_bypass: R3=%h", bus_nb.REG_A);
  endtask

  task automatic test_clear();
    int n;
    rfd = 4'd12; d = 16'hC0C0; wr = 1'b1; tick();
    wr = 1'b0; load = 1'b1; sel = 1'b1; tick();
    load = 1'b0; wr = 1'b1;
    for (int i = 8; i < 16; i++) begin
      rfd = RW'(i); d = 16'h0011 + 16'(i - 8); tick();
    end
    wr = 1'b0; rf1 = 4'd15; #1;
    vecs++; if (bus_byp.REG_A !== 16'h0018) begin errs++;
      $display("FAIL bank1_fill R15=%h, required 0018", bus_byp.REG_A); end
    clr = 1'b1; tick();
    clr = 1'b0; rf1 = 4'd12; rf2 = 4'd4;
    n = 0;
    while (!bus_byp.REG_Ready && n < 40) begin
      wr = (n == 2 || n == 3);
      rfd = (n == 2) ? 4'd12 : 4'd4;
      d = (n == 2) ? 16'hDEAD : 16'h4444;
      #1;
      vecs++; if (bus_byp.REG_A !== 16'h0 || bus_nb.REG_A !== 16'h0) begin errs++;
        $display("FAIL clr_bank_read cyc=%0d R12=%h, required 0000", n, bus_byp.REG_A); end
      tick();
      n++;
    end
    wr = 1'b0;
    vecs++; if (n != NREGS - NGLOBAL) begin errs++;
      $display("FAIL clr_bank_len got %0d cycles, required %0d", n, NREGS - NGLOBAL); end
    #1;
    vecs++; if (bus_byp.REG_B !== 16'h4444) begin errs++;
      $display("FAIL clr_bank_global R4=%h, required 4444", bus_byp.REG_B); end
    for (int i = 8; i < 16; i++) begin
      rf1 = RW'(i); #1;
      vecs++; if (bus_byp.REG_A !== 16'h0) begin errs++;
        $display("FAIL clr_bank_zero R%0d=%h, required 0000", i, bus_byp.REG_A); end
    end
    load = 1'b1; sel = 1'b0; tick();
    load = 1'b0; rf1 = 4'd12; rf2 = 4'd9; #1;
    vecs++; if (bus_byp.REG_A !== 16'hC0C0 || bus_byp.REG_B !== 16'h1234) begin errs++;
      $display("FAIL clr_bank_other R12=%h R9=%h, required C0C0 1234", bus_byp.REG_A, bus_byp.REG_B); end
    $display("test_clear: busy %0d cycles", n);
  endtask

  task automatic test_load_write();
    int n;
    load = 1'b1; sel = 1'b1; tick();
    load = 1'b0; wr = 1'b1; rfd = 4'd10; d = 16'h5555; tick();
    wr = 1'b0; load = 1'b1; sel = 1'b0; tick();
    wr = 1'b1; d = 16'h7777; load = 1'b1; sel = 1'b1; tick();
    wr = 1'b0; load = 1'b0; rf1 = 4'd10; #1;
    vecs++; if (bus_byp.REG_Bank !== 1'b1 || bus_byp.REG_A !== 16'h5555) begin errs++;
      $display("FAIL load_write_b1 bank=%0d R10=%h, required 1 5555", bus_byp.REG_Bank, bus_byp.REG_A); end
    load = 1'b1; sel = 1'b0; tick();
    load = 1'b0; #1;
    vecs++; if (bus_byp.REG_A !== 16'h7777) begin errs++;
      $display("FAIL load_write_b0 R10=%h, required 7777", bus_byp.REG_A); end
    load = 1'b1; sel = 1'b1; clr = 1'b1; tick();
    load = 1'b0; clr = 1'b0;
    n = 0;
    while (!bus_byp.REG_Ready && n < 40) begin tick(); n++; end
    #1;
    vecs++; if (bus_byp.REG_Bank !== 1'b1 || bus_byp.REG_A !== 16'h0 || n != NREGS - NGLOBAL) begin errs++;
      $display("FAIL clear_new_bank bank=%0d R10=%h n=%0d, required 1 0000 8", bus_byp.REG_Bank, bus_byp.REG_A, n); end
    load = 1'b1; sel = 1'b0; tick();
    load = 1'b0; #1;
    vecs++; if (bus_byp.REG_A !== 16'h7777) begin errs++;
      $display("FAIL clear_old_kept R10=%h, required 7777", bus_byp.REG_A); end
    $display("test_load_write: bank0 R10=%h", bus_byp.REG_A);
  endtask

  task automatic test_random();
    logic [TAM-1:0] ea, eb, ea_nb, eb_nb;
    for (int c = 0; c < 400; c++) begin
      rf1 = RW'($urandom_range(0, NREGS - 1));
      rf2 = RW'($urandom_range(0, NREGS - 1));
      rfd = RW'($urandom_range(0, NREGS - 1));
      d = TAM'($urandom); r1 = TAM'($urandom);
      wr = ($urandom_range(0, 1) == 1);
      load = ($urandom_range(0, 6) == 0);
      sel = BW'($urandom_range(0, NBANKS - 1));
      clr = ($urandom_range(0, 19) == 0);
      #1;
      ea = m_read(rf1, 1'b1); eb = m_read(rf2, 1'b1);
      ea_nb = m_read(rf1, 1'b0); eb_nb = m_read(rf2, 1'b0);
      vecs++; if (bus_byp.REG_A !== ea || bus_byp.REG_B !== eb) begin errs++;
        $display("FAIL rand_byp cyc=%0d A=%h B=%h, required %h %h", c, bus_byp.REG_A, bus_byp.REG_B, ea, eb); end
      vecs++; if (bus_nb.REG_A !== ea_nb || bus_nb.REG_B !== eb_nb) begin errs++;
        $display("FAIL rand_nobyp cyc=%0d A=%h B=%h, required %h %h", c, bus_nb.REG_A, bus_nb.REG_B, ea_nb, eb_nb); end
      vecs++; if (int'(bus_byp.REG_Bank) != m_sel || bus_byp.REG_Ready !== (busy_all == 0 && busy_bank == 0)) begin errs++;
        $display("FAIL rand_ctrl cyc=%0d bank=%0d ready=%b, required %0d %b", c, bus_byp.REG_Bank,
                 bus_byp.REG_Ready, m_sel, (busy_all == 0 && busy_bank == 0)); end
      tick();
    end
    wr = 1'b0; load = 1'b0; clr = 1'b0;
    $display("test_random: 400 cycles");
  endtask

  task automatic test_reset_mid_clear();
    int n;
    while (!bus_byp.REG_Ready && n < 40) begin tick(); n++; end
    load = 1'b1; sel = 1'b1; clr = 1'b1; tick();
    load = 1'b0; clr = 1'b0;
    tick(); tick();
    vecs++; if (bus_byp.REG_Bank !== 1'b1 || bus_byp.REG_Ready !== 1'b0) begin errs++;
      $display("FAIL mid_clear_pre bank=%0d ready=%b, required 1 0", bus_byp.REG_Bank, bus_byp.REG_Ready); end
    rst = 1'b0; model_reset(); #1;
    vecs++; if (bus_byp.REG_Bank !== 1'b0 || bus_byp.REG_Ready !== 1'b0 || bus_nb.REG_Bank !== 1'b0) begin errs++;
      $display("FAIL mid_clear_rst bank=%0d ready=%b, required 0 0", bus_byp.REG_Bank, bus_byp.REG_Ready); end
    tick();
    rst = 1'b1; rf1 = 4'd4;
    n = 0;
    while (!bus_byp.REG_Ready && n < 40) begin
      vecs++; if (bus_byp.REG_A !== 16'h0) begin errs++;
        $display("FAIL mid_clear_zero cyc=%0d R4=%h, required 0000", n, bus_byp.REG_A); end
      tick();
      n++;
    end
    vecs++; if (n != NREGS) begin errs++;
      $display("FAIL mid_clear_len got %0d cycles, required %0d", n, NREGS); end
    $display("test_reset_mid_clear: CLR_ALL took %0d cycles", n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bank_switch();
    test_bypass();
    test_clear();
    test_load_write();
    test_random();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
